vga_pip_scheduler: RTL and testbench
====================================

VGA_PIP_SCHEDULER -- requirements
Module: vga_pip_scheduler

Interface
REQ-001 Parameters SHALL be: H_ACT, default 640, active pixels per line; V_ACT, default 480, active lines per frame.
REQ-002 The ports SHALL be exactly those listed in REQ-003 to REQ-017, in that order.
REQ-003 iCLK  in  1  pixel clock; the block SHALL use this single clock.
REQ-004 iRST_N  in  1  reset; SHALL be asynchronous and active-low.
REQ-005 iRequest  in  1  pixel request from the VGA timing generator, one per active pixel.
REQ-006 iCoord_X, iCoord_Y  in  10 each  coordinate of the requested pixel.
REQ-007 iPIP_EN  in  1  PIP overlay enable (live value).
REQ-008 iPIP_X, iPIP_Y, iPIP_W, iPIP_H  in  10 each  PIP window origin and size (live values).
REQ-009 iBorder_R, iBorder_G, iBorder_B  in  10 each  border colour.
REQ-010 iMain_R, iMain_G, iMain_B  in  10 each  main FIFO data, valid one cycle after a read.
REQ-011 iMain_Empty  in  1  main FIFO empty.
REQ-012 iPip_R, iPip_G, iPip_B  in  10 each  PIP FIFO data, valid one cycle after a read.
REQ-013 iPip_Empty  in  1  PIP FIFO empty.
REQ-014 iClr_Err  in  1  clears the error status.
REQ-015 oMain_Read, oPip_Read  out  1 each  FIFO read strobes.
REQ-016 oRed, oGreen, oBlue  out  10 each  pixel data to the VGA timing generator.
REQ-017 oFrame_Start  out  1  frame-start pulse; oUnderflow  out  1  sticky error flag; oUnderflow_Cnt  out  8  error count.

Function
REQ-018 The FSM SHALL have two states: S_SYNC (the reset state) and S_RUN.
REQ-019 Frame start (FS) SHALL be defined as iRequest=1 with iCoord_X=0 and iCoord_Y=0.
REQ-020 S_SYNC SHALL move to S_RUN on FS; S_RUN SHALL remain in S_RUN until reset.
REQ-021 In S_SYNC the block SHALL issue no reads, and the output select for the following cycle SHALL be black.
REQ-022 On every FS, iPIP_EN/X/Y/W/H SHALL be captured into shadow registers, and the FS pixel itself SHALL use the newly captured values.
REQ-023 oFrame_Start SHALL be a registered one-cycle pulse in the cycle after each FS.
REQ-024 "In window" SHALL mean: shadow EN=1, W≠0, H≠0, px≤X<px+W and py≤Y<py+H.
REQ-025 All window sums SHALL be computed at 11 bits, so that windows extending past H_ACT/V_ACT are clipped and never wrap.
REQ-026 "Border" SHALL mean an in-window pixel with X=px, X=px+W-1, Y=py or Y=py+H-1.
REQ-027 In S_RUN (including the FS cycle), oMain_Read SHALL equal iRequest & ~iMain_Empty, combinationally, every pixel.
REQ-028 In S_RUN, oPip_Read SHALL equal iRequest & in-window & ~iPip_Empty, combinationally; border pixels SHALL still read the PIP FIFO so that it stays aligned.
REQ-029 The select SHALL be registered on the request cycle, with precedence:
  - black if the needed FIFO was empty (main for outside window, PIP for inside window);
  - else border;
  - else PIP if in window;
  - else main.
REQ-030 oRed/oGreen/oBlue SHALL be a combinational mux of the registered select: black=0, border=iBorder_*, PIP=iPip_*, main=iMain_*; latency SHALL be one cycle from iRequest.
REQ-031 The select SHALL hold its last value in cycles with iRequest=0.
REQ-032 An underflow SHALL be any request in S_RUN where a required read was blocked by empty (main always; PIP when in window).
REQ-033 On an underflow, oUnderflow SHALL set the next cycle, and oUnderflow_Cnt SHALL increment by 1 (once per pixel, even if both FIFOs are empty) and saturate at 255.
REQ-034 iClr_Err SHALL clear oUnderflow and oUnderflow_Cnt to 0, and SHALL take priority over a simultaneous underflow.

Reset
REQ-035 While iRST_N=0 the block SHALL hold: state S_SYNC, shadow registers 0, select black, oFrame_Start=0, oUnderflow=0, oUnderflow_Cnt=0.
REQ-036 While iRST_N=0 the block SHALL hold oMain_Read=0 and oPip_Read=0 regardless of other inputs.
REQ-037 A reset asserted mid-frame SHALL return the block to S_SYNC, and it SHALL issue no reads until the next FS.

Verification
REQ-038 Bench SHALL cover start-up: reset release, requests beginning at (5,3) -> no reads and outputs 0 until (0,0), then oMain_Read=1 at (0,0) and oFrame_Start=1 the next cycle.
REQ-039 Bench SHALL cover window overlay: EN=1, X=100, Y=50, W=4, H=3, frame walked -> oPip_Read high only for X∈100..103 and Y∈50..52; border shown at all those pixels except (101..102, 51), which show iPip_*.
REQ-040 Bench SHALL cover clipping: X=638, W=10 -> oPip_Read only at X=638 and X=639, and no reads at X=0..7 of the same line.
REQ-041 Bench SHALL cover config shadowing: iPIP_X changed mid-frame from 100 to 200 -> the window stays at 100 until the next FS, then moves to 200.
REQ-042 Bench SHALL cover underflow: iMain_Empty=1 for 3 requests outside the window -> oMain_Read=0 and black output for those 3 pixels, oUnderflow=1 and oUnderflow_Cnt=3; then iClr_Err asserted together with a 4th underflow -> oUnderflow_Cnt=0.
REQ-043 Bench SHALL cover saturation and mid-frame reset: 300 underflows -> oUnderflow_Cnt=255; iRST_N pulsed mid-line -> reads stop at once and resume only at the next (0,0).

Source files
------------

// File: rtl/vga_pip_scheduler.sv
// Pixel scheduler for a VGA picture-in-picture overlay: pops the main and PIP
// FIFOs per requested pixel, muxes border/PIP/main/black and tracks underflows.
module vga_pip_scheduler #(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iRequest,
    input  logic [9:0] iCoord_X,
    input  logic [9:0] iCoord_Y,
    input  logic       iPIP_EN,
    input  logic [9:0] iPIP_X,
    input  logic [9:0] iPIP_Y,
    input  logic [9:0] iPIP_W,
    input  logic [9:0] iPIP_H,
    input  logic [9:0] iBorder_R,
    input  logic [9:0] iBorder_G,
    input  logic [9:0] iBorder_B,
    input  logic [9:0] iMain_R,
    input  logic [9:0] iMain_G,
    input  logic [9:0] iMain_B,
    input  logic       iMain_Empty,
    input  logic [9:0] iPip_R,
    input  logic [9:0] iPip_G,
    input  logic [9:0] iPip_B,
    input  logic       iPip_Empty,
    input  logic       iClr_Err,
    output logic       oMain_Read,
    output logic       oPip_Read,
    output logic [9:0] oRed,
    output logic [9:0] oGreen,
    output logic [9:0] oBlue,
    output logic       oFrame_Start,
    output logic       oUnderflow,
    output logic [7:0] oUnderflow_Cnt
);

    typedef enum logic {
        S_SYNC,
        S_RUN
    } state_t;

    typedef enum logic [1:0] {
        SEL_BLACK,
        SEL_BORDER,
        SEL_PIP,
        SEL_MAIN
    } sel_t;

    localparam logic [10:0] L_H_ACT = 11'(H_ACT);
    localparam logic [10:0] L_V_ACT = 11'(V_ACT);

    state_t      r_state;
    state_t      w_next_state;
    sel_t        r_sel;
    sel_t        w_sel_next;

    logic        r_en;
    logic [9:0]  r_px;
    logic [9:0]  r_py;
    logic [9:0]  r_pw;
    logic [9:0]  r_ph;
    logic        r_frame_start;
    logic        r_underflow;
    logic [7:0]  r_underflow_cnt;

    logic        w_fs;
    logic        w_active;
    logic        w_en;
    logic [9:0]  w_px;
    logic [9:0]  w_py;
    logic [9:0]  w_pw;
    logic [9:0]  w_ph;
    logic [10:0] w_x11;
    logic [10:0] w_y11;
    logic [10:0] w_px11;
    logic [10:0] w_py11;
    logic [10:0] w_xend;
    logic [10:0] w_yend;
    logic [10:0] w_xlast;
    logic [10:0] w_ylast;
    logic        w_in_x;
    logic        w_in_y;
    logic        w_in_win;
    logic        w_border;
    logic        w_main_read;
    logic        w_pip_read;
    logic        w_underflow;

    assign w_fs     = iRequest && (iCoord_X == 10'd0) && (iCoord_Y == 10'd0);
    assign w_active = (r_state == S_RUN) || w_fs;

    // The frame-start pixel already uses the configuration being captured.
    assign w_en = w_fs ? iPIP_EN : r_en;
    assign w_px = w_fs ? iPIP_X  : r_px;
    assign w_py = w_fs ? iPIP_Y  : r_py;
    assign w_pw = w_fs ? iPIP_W  : r_pw;
    assign w_ph = w_fs ? iPIP_H  : r_ph;

    assign w_x11   = {1'b0, iCoord_X};
    assign w_y11   = {1'b0, iCoord_Y};
    assign w_px11  = {1'b0, w_px};
    assign w_py11  = {1'b0, w_py};
    assign w_xend  = w_px11 + {1'b0, w_pw};
    assign w_yend  = w_py11 + {1'b0, w_ph};
    assign w_xlast = w_xend - 11'd1;
    assign w_ylast = w_yend - 11'd1;

    assign w_in_x   = (w_x11 >= w_px11) && (w_x11 < w_xend) && (w_x11 < L_H_ACT);
    assign w_in_y   = (w_y11 >= w_py11) && (w_y11 < w_yend) && (w_y11 < L_V_ACT);
    assign w_in_win = w_en && (w_pw != 10'd0) && (w_ph != 10'd0) && w_in_x && w_in_y;
    assign w_border = w_in_win && ((w_x11 == w_px11) || (w_x11 == w_xlast) ||
                                   (w_y11 == w_py11) || (w_y11 == w_ylast));

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= S_SYNC;
            r_sel   <= SEL_BLACK;
        end else begin
            r_state <= w_next_state;
            r_sel   <= w_sel_next;
        end
    end

    // Border pixels still pop the PIP FIFO so its stream stays aligned with the window.
    always_comb begin
        w_next_state = r_state;
        w_sel_next   = r_sel;
        w_main_read  = 1'b0;
        w_pip_read   = 1'b0;
        w_underflow  = 1'b0;
        if (r_state == S_SYNC && w_fs) begin
            w_next_state = S_RUN;
        end
        if (!w_active) begin
            w_sel_next = SEL_BLACK;
        end else if (iRequest) begin
            w_main_read = ~iMain_Empty;
            w_pip_read  = w_in_win & ~iPip_Empty;
            w_underflow = iMain_Empty | (w_in_win & iPip_Empty);
            if (w_in_win ? iPip_Empty : iMain_Empty) begin
                w_sel_next = SEL_BLACK;
            end else if (w_border) begin
                w_sel_next = SEL_BORDER;
            end else if (w_in_win) begin
                w_sel_next = SEL_PIP;
            end else begin
                w_sel_next = SEL_MAIN;
            end
        end
        if (!iRST_N) begin
            w_main_read = 1'b0;
            w_pip_read  = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_en          <= 1'b0;
            r_px          <= 10'd0;
            r_py          <= 10'd0;
            r_pw          <= 10'd0;
            r_ph          <= 10'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_fs;
            if (w_fs) begin
                r_en <= iPIP_EN;
                r_px <= iPIP_X;
                r_py <= iPIP_Y;
                r_pw <= iPIP_W;
                r_ph <= iPIP_H;
            end
        end
    end

    // Clear wins over a coincident underflow; the count saturates at 255.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_underflow     <= 1'b0;
            r_underflow_cnt <= 8'd0;
        end else if (iClr_Err) begin
            r_underflow     <= 1'b0;
            r_underflow_cnt <= 8'd0;
        end else if (w_underflow) begin
            r_underflow <= 1'b1;
            if (r_underflow_cnt != 8'hFF) begin
                r_underflow_cnt <= r_underflow_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        oRed   = 10'd0;
        oGreen = 10'd0;
        oBlue  = 10'd0;
        case (r_sel)
            SEL_BORDER: begin
                oRed   = iBorder_R;
                oGreen = iBorder_G;
                oBlue  = iBorder_B;
            end
            SEL_PIP: begin
                oRed   = iPip_R;
                oGreen = iPip_G;
                oBlue  = iPip_B;
            end
            SEL_MAIN: begin
                oRed   = iMain_R;
                oGreen = iMain_G;
                oBlue  = iMain_B;
            end
            default: begin
                oRed   = 10'd0;
                oGreen = 10'd0;
                oBlue  = 10'd0;
            end
        endcase
    end

    assign oMain_Read     = w_main_read;
    assign oPip_Read      = w_pip_read;
    assign oFrame_Start   = r_frame_start;
    assign oUnderflow     = r_underflow;
    assign oUnderflow_Cnt = r_underflow_cnt;

endmodule

// File: tb/tb_vga_pip_scheduler.sv
// Self-checking bench for vga_pip_scheduler: directed scenarios plus random
// traffic, all compared against a pixel-level behavioural model.
module tb_vga_pip_scheduler;

    logic       iCLK;
    logic       iRST_N;
    logic       iRequest;
    logic [9:0] iCoord_X;
    logic [9:0] iCoord_Y;
    logic       iPIP_EN;
    logic [9:0] iPIP_X;
    logic [9:0] iPIP_Y;
    logic [9:0] iPIP_W;
    logic [9:0] iPIP_H;
    logic [9:0] iBorder_R;
    logic [9:0] iBorder_G;
    logic [9:0] iBorder_B;
    logic [9:0] iMain_R;
    logic [9:0] iMain_G;
    logic [9:0] iMain_B;
    logic       iMain_Empty;
    logic [9:0] iPip_R;
    logic [9:0] iPip_G;
    logic [9:0] iPip_B;
    logic       iPip_Empty;
    logic       iClr_Err;
    logic       oMain_Read;
    logic       oPip_Read;
    logic [9:0] oRed;
    logic [9:0] oGreen;
    logic [9:0] oBlue;
    logic       oFrame_Start;
    logic       oUnderflow;
    logic [7:0] oUnderflow_Cnt;

    vga_pip_scheduler #(.H_ACT(640), .V_ACT(480)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iRequest(iRequest),
        .iCoord_X(iCoord_X), .iCoord_Y(iCoord_Y),
        .iPIP_EN(iPIP_EN), .iPIP_X(iPIP_X), .iPIP_Y(iPIP_Y), .iPIP_W(iPIP_W), .iPIP_H(iPIP_H),
        .iBorder_R(iBorder_R), .iBorder_G(iBorder_G), .iBorder_B(iBorder_B),
        .iMain_R(iMain_R), .iMain_G(iMain_G), .iMain_B(iMain_B), .iMain_Empty(iMain_Empty),
        .iPip_R(iPip_R), .iPip_G(iPip_G), .iPip_B(iPip_B), .iPip_Empty(iPip_Empty),
        .iClr_Err(iClr_Err),
        .oMain_Read(oMain_Read), .oPip_Read(oPip_Read),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
        .oFrame_Start(oFrame_Start), .oUnderflow(oUnderflow), .oUnderflow_Cnt(oUnderflow_Cnt)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic       mainRd;
        logic       pipRd;
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
        logic       fs;
        logic       uf;
        logic [7:0] cnt;
    } pix_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int K_BLACK  = 0;
    localparam int K_BORDER = 1;
    localparam int K_PIP    = 2;
    localparam int K_MAIN   = 3;

    int total = 0;
    int bad   = 0;

    // Model state: frame-locked flag, captured window, shown source, error status.
    bit mRun;
    bit mEn;
    int mPx, mPy, mPw, mPh;
    int mShow;
    bit mUf;
    int mCnt;

    task automatic modelReset();
        mRun = 0; mEn = 0; mPx = 0; mPy = 0; mPw = 0; mPh = 0;
        mShow = K_BLACK; mUf = 0; mCnt = 0;
    endtask

    task automatic modelPixel(input int x, input int y, input bit req, input bit me,
                              input bit pe, input bit clr, output pix_t e);
        bit fs, live, inWin, edgePix, uf;
        fs = req && x == 0 && y == 0;
        if (fs) begin
            mEn = iPIP_EN; mPx = int'(iPIP_X); mPy = int'(iPIP_Y);
            mPw = int'(iPIP_W); mPh = int'(iPIP_H);
        end
        live    = mRun || fs;
        inWin   = mEn && mPw > 0 && mPh > 0 && x >= mPx && x < mPx + mPw &&
                  y >= mPy && y < mPy + mPh && x < SCREEN_W && y < SCREEN_H;
        edgePix = inWin && (x == mPx || x == mPx + mPw - 1 || y == mPy || y == mPy + mPh - 1);
        e = '0;
        e.mainRd = live && req && !me;
        e.pipRd  = live && req && inWin && !pe;
        uf = live && req && (me || (inWin && pe));
        if (!live) mShow = K_BLACK;
        else if (req) begin
            if ((inWin && pe) || (!inWin && me)) mShow = K_BLACK;
            else if (edgePix) mShow = K_BORDER;
            else if (inWin) mShow = K_PIP;
            else mShow = K_MAIN;
        end
        if (clr) begin
            mUf = 0; mCnt = 0;
        end else if (uf) begin
            mUf = 1;
            if (mCnt < 255) mCnt = mCnt + 1;
        end
        if (fs) mRun = 1;
        case (mShow)
            K_BORDER: begin e.r = iBorder_R; e.g = iBorder_G; e.b = iBorder_B; end
            K_PIP:    begin e.r = iPip_R;    e.g = iPip_G;    e.b = iPip_B;    end
            K_MAIN:   begin e.r = iMain_R;   e.g = iMain_G;   e.b = iMain_B;   end
            default:  begin e.r = '0;        e.g = '0;        e.b = '0;        end
        endcase
        e.fs  = fs;
        e.uf  = mUf;
        e.cnt = 8'(mCnt);
    endtask

    task automatic drivePixel(input int x, input int y, input bit req, input bit me,
                              input bit pe, input bit clr, output pix_t o);
        @(negedge iCLK);
        iRequest = req; iCoord_X = 10'(x); iCoord_Y = 10'(y);
        iMain_Empty = me; iPip_Empty = pe; iClr_Err = clr;
        iMain_R = 10'($urandom); iMain_G = 10'($urandom); iMain_B = 10'($urandom);
        iPip_R = 10'($urandom); iPip_G = 10'($urandom); iPip_B = 10'($urandom);
        iBorder_R = 10'($urandom); iBorder_G = 10'($urandom); iBorder_B = 10'($urandom);
        #1;
        o = '0;
        o.mainRd = oMain_Read;
        o.pipRd  = oPip_Read;
        @(posedge iCLK);
        #1;
        o.r = oRed; o.g = oGreen; o.b = oBlue;
        o.fs = oFrame_Start; o.uf = oUnderflow; o.cnt = oUnderflow_Cnt;
    endtask

    task automatic setWindow(input bit en, input int x, input int y, input int w, input int h);
        iPIP_EN = en; iPIP_X = 10'(x); iPIP_Y = 10'(y); iPIP_W = 10'(w); iPIP_H = 10'(h);
    endtask

    task automatic test_reset();
        pix_t o;
        for (int i = 0; i < 4; i++) begin
            drivePixel(i == 0 ? 0 : int'($urandom_range(1, 639)), i == 0 ? 0 : int'($urandom_range(0, 479)),
                       1, 0, 0, 0, o);
            total++;
            if (o !== pix_t'(0)) begin
                bad++;
                $display("[TB] FAIL reset_hold %0d: got %h want 0", i, o);
            end
        end
        @(negedge iCLK);
        iRST_N = 1'b1;
        modelReset();
    endtask

    task automatic test_startup();
        pix_t o, e;
        setWindow(0, 0, 0, 0, 0);
        for (int x = 5; x < 13; x++) begin
            drivePixel(x, 3, 1, 0, 0, 0, o);
            modelPixel(x, 3, 1, 0, 0, 0, e);
            total++;
            if (o !== e || o.mainRd !== 1'b0 || o.r !== 10'd0) begin
                bad++;
                $display("[TB] FAIL startup_presync (%0d,3): got %h want %h", x, o, e);
            end
        end
        drivePixel(0, 0, 1, 0, 0, 0, o);
        modelPixel(0, 0, 1, 0, 0, 0, e);
        total++;
        if (o !== e) begin
            bad++;
            $display("[TB] FAIL startup_fs: got %h want %h", o, e);
        end
        total++;
        if (o.mainRd !== 1'b1 || o.fs !== 1'b1) begin
            bad++;
            $display("[TB] FAIL startup_read_pulse: got rd=%b fs=%b want rd=1 fs=1", o.mainRd, o.fs);
        end
    endtask

    task automatic test_window();
        pix_t o, e;
        int pipReads = 0, pipShown = 0, borderShown = 0;
        setWindow(1, 100, 50, 4, 3);
        drivePixel(0, 0, 1, 0, 0, 0, o);
        modelPixel(0, 0, 1, 0, 0, 0, e);
        total++;
        if (o !== e) begin
            bad++;
            $display("[TB] FAIL window_fs: got %h want %h", o, e);
        end
        for (int y = 48; y < 55; y++) begin
            for (int x = 97; x < 107; x++) begin
                drivePixel(x, y, 1, 0, 0, 0, o);
                modelPixel(x, y, 1, 0, 0, 0, e);
                total++;
                if (o !== e) begin
                    bad++;
                    $display("[TB] FAIL window (%0d,%0d): got %h want %h", x, y, o, e);
                end
                if (o.pipRd) pipReads++;
                if (o.r == iPip_R && o.g == iPip_G && o.b == iPip_B) pipShown++;
                if (o.r == iBorder_R && o.g == iBorder_G && o.b == iBorder_B) borderShown++;
            end
        end
        total++;
        if (pipReads != 12 || pipShown != 2 || borderShown != 10) begin
            bad++;
            $display("[TB] FAIL window_counts: got reads=%0d pip=%0d border=%0d want 12 2 10",
                     pipReads, pipShown, borderShown);
        end
    endtask

    task automatic test_clip();
        pix_t o, e;
        int lowReads = 0, highReads = 0;
        setWindow(1, 638, 10, 10, 2);
        drivePixel(0, 0, 1, 0, 0, 0, o);
        modelPixel(0, 0, 1, 0, 0, 0, e);
        for (int i = 0; i < 18; i++) begin
            int x;
            x = (i < 8) ? i : 622 + i;
            drivePixel(x, 10, 1, 0, 0, 0, o);
            modelPixel(x, 10, 1, 0, 0, 0, e);
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL clip (%0d,10): got %h want %h", x, o, e);
            end
            if (o.pipRd && i < 8) lowReads++;
            if (o.pipRd && x >= 638) highReads++;
            else if (o.pipRd && i >= 8) lowReads++;
        end
        total++;
        if (lowReads != 0 || highReads != 2) begin
            bad++;
            $display("[TB] FAIL clip_counts: got stray=%0d edge=%0d want 0 2", lowReads, highReads);
        end
    endtask

    task automatic test_shadow();
        pix_t o, e;
        int xs[5] = '{101, 101, 201, 201, 101};
        bit want[5] = '{1, 1, 0, 1, 0};
        setWindow(1, 100, 50, 4, 3);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) iPIP_X = 10'd200;
            if (i == 0 || i == 3) begin
                drivePixel(0, 0, 1, 0, 0, 0, o);
                modelPixel(0, 0, 1, 0, 0, 0, e);
            end
            drivePixel(xs[i], 51, 1, 0, 0, 0, o);
            modelPixel(xs[i], 51, 1, 0, 0, 0, e);
            total++;
            if (o !== e || o.pipRd !== want[i]) begin
                bad++;
                $display("[TB] FAIL shadow step %0d x=%0d: got %h want %h pipRd=%b",
                         i, xs[i], o, e, want[i]);
            end
        end
    endtask

    task automatic test_underflow();
        pix_t o, e;
        setWindow(0, 0, 0, 0, 0);
        drivePixel(3, 3, 0, 0, 0, 1, o);
        modelPixel(3, 3, 0, 0, 0, 1, e);
        for (int i = 0; i < 3; i++) begin
            drivePixel(10 + i, 20, 1, 1, 0, 0, o);
            modelPixel(10 + i, 20, 1, 1, 0, 0, e);
            total++;
            if (o !== e || o.mainRd !== 1'b0 || o.r !== 10'd0 || o.g !== 10'd0 || o.b !== 10'd0) begin
                bad++;
                $display("[TB] FAIL underflow_pixel %0d: got %h want %h", i, o, e);
            end
        end
        total++;
        if (o.uf !== 1'b1 || o.cnt !== 8'd3) begin
            bad++;
            $display("[TB] FAIL underflow_count: got uf=%b cnt=%0d want 1 3", o.uf, o.cnt);
        end
        drivePixel(13, 20, 1, 1, 0, 1, o);
        modelPixel(13, 20, 1, 1, 0, 1, e);
        total++;
        if (o !== e || o.cnt !== 8'd0 || o.uf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL underflow_clear: got %h want %h", o, e);
        end
    endtask

    task automatic test_saturation();
        pix_t o, e;
        for (int i = 0; i < 300; i++) begin
            int x, y;
            bit pe;
            x = int'($urandom_range(1, 639));
            y = int'($urandom_range(0, 479));
            pe = 1'($urandom);
            drivePixel(x, y, 1, 1, pe, 0, o);
            modelPixel(x, y, 1, 1, pe, 0, e);
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL saturation %0d: got %h want %h", i, o, e);
            end
        end
        total++;
        if (o.cnt !== 8'd255 || o.uf !== 1'b1) begin
            bad++;
            $display("[TB] FAIL saturation_final: got cnt=%0d uf=%b want 255 1", o.cnt, o.uf);
        end
    endtask

    task automatic test_midreset();
        pix_t o, e;
        for (int x = 20; x < 24; x++) begin
            drivePixel(x, 5, 1, 0, 0, 0, o);
            modelPixel(x, 5, 1, 0, 0, 0, e);
            total++;
            if (o !== e || o.mainRd !== 1'b1) begin
                bad++;
                $display("[TB] FAIL midreset_before (%0d,5): got %h want %h", x, o, e);
            end
        end
        @(negedge iCLK);
        iRST_N = 1'b0; iRequest = 1'b1; iCoord_X = 10'd24; iCoord_Y = 10'd5;
        iMain_Empty = 1'b0; iPip_Empty = 1'b0; iClr_Err = 1'b0;
        #1;
        total++;
        if (oMain_Read !== 1'b0 || oPip_Read !== 1'b0 || oUnderflow_Cnt !== 8'd0 || oUnderflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_assert: got rd=%b/%b cnt=%0d uf=%b want 0/0 0 0",
                     oMain_Read, oPip_Read, oUnderflow_Cnt, oUnderflow);
        end
        @(negedge iCLK);
        iRST_N = 1'b1;
        modelReset();
        for (int i = 0; i < 10; i++) begin
            int x, y;
            x = (i < 6) ? 25 + i : i - 5;
            y = (i < 6) ? 5 : 6;
            drivePixel(x, y, 1, 0, 0, 0, o);
            modelPixel(x, y, 1, 0, 0, 0, e);
            total++;
            if (o !== e || o.mainRd !== 1'b0) begin
                bad++;
                $display("[TB] FAIL midreset_idle (%0d,%0d): got %h want %h", x, y, o, e);
            end
        end
        drivePixel(0, 0, 1, 0, 0, 0, o);
        modelPixel(0, 0, 1, 0, 0, 0, e);
        total++;
        if (o !== e || o.mainRd !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset_resume: got %h want %h", o, e);
        end
    endtask

    task automatic test_random();
        pix_t o, e;
        for (int i = 0; i < 400; i++) begin
            int x, y;
            bit req, me, pe, clr;
            if ($urandom_range(0, 19) == 0)
                setWindow(1'($urandom), int'($urandom_range(0, 700)), int'($urandom_range(0, 500)),
                          int'($urandom_range(0, 60)), int'($urandom_range(0, 40)));
            if ($urandom_range(0, 49) == 0) begin
                x = 0; y = 0;
            end else begin
                x = int'($urandom_range(0, 639)); y = int'($urandom_range(0, 479));
            end
            req = ($urandom_range(0, 3) != 0);
            me  = ($urandom_range(0, 7) == 0);
            pe  = ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 31) == 0);
            drivePixel(x, y, req, me, pe, clr, o);
            modelPixel(x, y, req, me, pe, clr, e);
            total++;
            if (o !== e) begin
                bad++;
                $display("[TB] FAIL random %0d (%0d,%0d) req=%b me=%b pe=%b clr=%b: got %h want %h",
                         i, x, y, req, me, pe, clr, o, e);
            end
        end
    endtask

    initial begin
        iRST_N = 1'b0; iRequest = 1'b0; iCoord_X = '0; iCoord_Y = '0;
        iMain_Empty = 1'b0; iPip_Empty = 1'b0; iClr_Err = 1'b0;
        iMain_R = '0; iMain_G = '0; iMain_B = '0;
        iPip_R = '0; iPip_G = '0; iPip_B = '0;
        iBorder_R = '0; iBorder_G = '0; iBorder_B = '0;
        setWindow(0, 0, 0, 0, 0);
        modelReset();
        test_reset();
        test_startup();
        test_window();
        test_clip();
        test_shadow();
        test_underflow();
        test_saturation();
        test_midreset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
